cv32e40p_x_disp_mo: RTL and testbench

Parametrised successor of the x-interface dispatcher. It supports multiple outstanding offloads and keeps a per-register pending-writer count. Each in-flight instruction is tracked by ID in a small table, and the commit handshake is registered. It sits between the ID stage and the CORE-V-XIF issue/commit/result/mem channels.

---
 rtl/cv32e40p_x_disp_mo.sv | 205 ++++++++++++++++++++
 tb/tb_cv32e40p_x_disp_mo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_x_disp_mo.sv
// cv32e40p_x_disp_mo: multi-outstanding CORE-V-XIF dispatcher with in-flight table and per-register writer scoreboard.
// Define CV32E40P_X_RESULT_ID_CHECK_EN to match results by ID (else results retire the oldest entry).
module cv32e40p_x_disp_mo #(
    parameter int X_ID_WIDTH      = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SB_CNT_WIDTH    = 2,
    parameter int MEM_CNT_WIDTH   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 x_illegal_insn_dec_i,
    input  logic                                 x_branch_or_jump_i,
    input  logic                                 id_ready_i,
    input  logic [4:0]                           x_waddr_id_i,
    input  logic [2:0][4:0]                      x_rs_addr_i,
    input  logic [2:0]                           x_regs_used_i,
    input  logic [4:0]                           x_waddr_ex_i,
    input  logic [4:0]                           x_waddr_wb_i,
    input  logic                                 x_we_ex_i,
    input  logic                                 x_we_wb_i,
    input  logic                                 x_data_req_dec_i,
    input  logic                                 flush_i,
    output logic                                 x_issue_valid_o,
    input  logic                                 x_issue_ready_i,
    input  logic                                 x_issue_resp_accept_i,
    input  logic                                 x_issue_resp_writeback_i,
    input  logic                                 x_issue_resp_loadstore_i,
    output logic [X_ID_WIDTH-1:0]                x_issue_req_id_o,
    output logic [2:0]                           x_issue_req_rs_valid_o,
    output logic                                 x_commit_valid_o,
    output logic [X_ID_WIDTH-1:0]                x_commit_id_o,
    output logic                                 x_commit_kill_o,
    input  logic                                 x_result_valid_i,
    output logic                                 x_result_ready_o,
    input  logic [X_ID_WIDTH-1:0]                x_result_id_i,
    input  logic [4:0]                           x_result_rd_i,
    input  logic                                 x_result_we_i,
    input  logic                                 x_mem_valid_i,
    output logic                                 x_mem_ready_o,
    output logic                                 x_mem_data_req_o,
    output logic                                 x_stall_o,
    output logic                                 x_illegal_insn_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] x_outstanding_o,
    output logic                                 x_protocol_err_o
);
    localparam int NE = MAX_OUTSTANDING;
    localparam int OW = $clog2(NE + 1);
    localparam int SW = SB_CNT_WIDTH + 2;

    logic [X_ID_WIDTH-1:0]    id_q, id_d, commit_id_q, commit_id_d;
    logic                     offloaded_q, offloaded_d, commit_valid_q, commit_valid_d, prot_err_q, prot_err_d;
    logic [MEM_CNT_WIDTH-1:0] mem_cnt_q, mem_cnt_d;
    logic [NE-1:0]            valid_q, valid_d, twe_q, twe_d, alloc_mask, kill_mask, res_mask;
    logic [X_ID_WIDTH-1:0]    tid_q [NE];
    logic [X_ID_WIDTH-1:0]    tid_d [NE];
    logic [4:0]               trd_q [NE];
    logic [4:0]               trd_d [NE];
    logic [SB_CNT_WIDTH-1:0]  sb_q [32];
    logic [SB_CNT_WIDTH-1:0]  sb_d [32];
    logic [OW-1:0]            cnt;
    logic [SW-1:0]            nxt;
    logic table_full, rd_sat, issue_valid, hs, acc, kill, res_v, mem_v, dep, inc, dk, dr, mem_inc, mem_dec;

    always_comb begin
        cnt        = '0;
        alloc_mask = '0;
        for (int e = NE - 1; e >= 0; e--) begin
            cnt = cnt + OW'(valid_q[e]);
            if (!valid_q[e]) alloc_mask = NE'(1) << e;
        end
        // A saturated mem-op counter blocks issue exactly like a full table.
        table_full  = (&valid_q) | (&mem_cnt_q);
        rd_sat      = &sb_q[x_waddr_id_i];
        issue_valid = ~rst_i & x_illegal_insn_dec_i & ~x_branch_or_jump_i & ~offloaded_q & ~table_full & ~rd_sat;
        hs          = issue_valid & x_issue_ready_i;
        acc         = hs & x_issue_resp_accept_i;
        kill        = commit_valid_q & flush_i;
        res_v       = x_result_valid_i & ~rst_i;
        mem_v       = x_mem_valid_i & ~rst_i;
        kill_mask   = '0;
        for (int e = 0; e < NE; e++)
            kill_mask[e] = kill & valid_q[e] & (tid_q[e] == commit_id_q);
    end

`ifdef CV32E40P_X_RESULT_ID_CHECK_EN
    always_comb begin
        res_mask = '0;
        for (int e = 0; e < NE; e++)
            res_mask[e] = res_v & valid_q[e] & ~kill_mask[e] & (tid_q[e] == x_result_id_i);
        prot_err_d = res_v & ~(|res_mask);
    end
`else
    logic [X_ID_WIDTH-1:0] age, best_age;
    logic                  unused_result_id;
    assign unused_result_id = ^x_result_id_i;
    // Oldest live entry is the one whose ID lies furthest behind the issue counter.
    always_comb begin
        res_mask = '0;
        best_age = '0;
        age      = '0;
        for (int e = 0; e < NE; e++) begin
            age = id_q - tid_q[e];
            if (res_v && valid_q[e] && !kill_mask[e] && (res_mask == '0 || age > best_age)) begin
                res_mask    = '0;
                res_mask[e] = 1'b1;
                best_age    = age;
            end
        end
        prot_err_d = 1'b0;
    end
`endif

    always_comb begin
        inc = 1'b0;
        dk  = 1'b0;
        dr  = 1'b0;
        nxt = '0;
        for (int r = 0; r < 32; r++) begin
            inc = acc & x_issue_resp_writeback_i & (x_waddr_id_i == 5'(r));
            dk  = 1'b0;
            for (int e = 0; e < NE; e++)
                dk = dk | (kill_mask[e] & twe_q[e] & (trd_q[e] == 5'(r)));
            dr    = (|res_mask) & x_result_we_i & (x_result_rd_i == 5'(r));
            nxt   = {2'b00, sb_q[r]} + SW'(inc) - SW'(dk) - SW'(dr);
            sb_d[r] = (r == 0 || nxt[SW-1]) ? '0 : nxt[SB_CNT_WIDTH-1:0];
        end
    end

    always_comb begin
        valid_d = (valid_q & ~kill_mask & ~res_mask) | (acc ? alloc_mask : '0);
        tid_d   = tid_q;
        trd_d   = trd_q;
        twe_d   = twe_q;
        for (int e = 0; e < NE; e++)
            if (acc && alloc_mask[e]) begin
                tid_d[e] = id_q;
                trd_d[e] = x_waddr_id_i;
                twe_d[e] = x_issue_resp_writeback_i;
            end
        id_d           = hs ? id_q + X_ID_WIDTH'(1) : id_q;
        offloaded_d    = id_ready_i ? 1'b0 : (acc | offloaded_q);
        commit_valid_d = hs;
        commit_id_d    = id_q;
        mem_inc        = acc & x_issue_resp_loadstore_i & ~(&mem_cnt_q);
        mem_dec        = mem_v & (mem_cnt_q != '0);
        mem_cnt_d      = (mem_inc & ~mem_dec) ? mem_cnt_q + MEM_CNT_WIDTH'(1) :
                         (mem_dec & ~mem_inc) ? mem_cnt_q - MEM_CNT_WIDTH'(1) : mem_cnt_q;
    end

    always_comb begin
        dep                    = 1'b0;
        x_issue_req_rs_valid_o = '0;
        for (int i = 0; i < 3; i++) begin
            x_issue_req_rs_valid_o[i] = (x_rs_addr_i[i] == 5'd0) |
                ~((sb_q[x_rs_addr_i[i]] != '0) | (x_we_ex_i & (x_waddr_ex_i == x_rs_addr_i[i])) |
                  (x_we_wb_i & (x_waddr_wb_i == x_rs_addr_i[i])));
            dep = dep | (x_regs_used_i[i] & (sb_q[x_rs_addr_i[i]] != '0));
        end
    end

    assign x_issue_valid_o  = issue_valid;
    assign x_issue_req_id_o = id_q;
    assign x_commit_valid_o = commit_valid_q;
    assign x_commit_id_o    = commit_id_q;
    assign x_commit_kill_o  = kill;
    assign x_result_ready_o = ~rst_i;
    assign x_mem_ready_o    = mem_v;
    assign x_mem_data_req_o = mem_v;
    assign x_illegal_insn_o = hs & ~x_issue_resp_accept_i;
    assign x_outstanding_o  = cnt;
    assign x_protocol_err_o = prot_err_q;
    assign x_stall_o = (issue_valid & ~x_issue_ready_i) | dep | (x_data_req_dec_i & (mem_cnt_q != '0)) |
                       (x_illegal_insn_dec_i & x_branch_or_jump_i) | (x_illegal_insn_dec_i & (table_full | rd_sat)) |
                       (x_mem_valid_i & ~hs);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_q           <= '0;
            commit_id_q    <= '0;
            offloaded_q    <= 1'b0;
            commit_valid_q <= 1'b0;
            prot_err_q     <= 1'b0;
            mem_cnt_q      <= '0;
            valid_q        <= '0;
            twe_q          <= '0;
            for (int e = 0; e < NE; e++) begin
                tid_q[e] <= '0;
                trd_q[e] <= '0;
            end
            for (int r = 0; r < 32; r++) sb_q[r] <= '0;
        end else begin
            id_q           <= id_d;
            commit_id_q    <= commit_id_d;
            offloaded_q    <= offloaded_d;
            commit_valid_q <= commit_valid_d;
            prot_err_q     <= prot_err_d;
            mem_cnt_q      <= mem_cnt_d;
            valid_q        <= valid_d;
            twe_q          <= twe_d;
            tid_q          <= tid_d;
            trd_q          <= trd_d;
            sb_q           <= sb_d;
        end
    end
endmodule

// File: tb/tb_cv32e40p_x_disp_mo.sv
// tb_cv32e40p_x_disp_mo: directed stimulus with a queue-based reference model checked every cycle.
module tb_cv32e40p_x_disp_mo;
    localparam int NE = 4;

    logic clk = 1'b0;
    logic rst;
    logic illegal, bj, id_ready, we_ex, we_wb, data_req_dec, flush;
    logic issue_ready, accept, wb, ls, res_valid, res_we, mem_valid;
    logic [4:0] waddr, waddr_ex, waddr_wb, res_rd;
    logic [2:0][4:0] rs;
    logic [2:0] regs_used;
    logic [3:0] res_id;
    logic x_issue_valid_o, x_commit_valid_o, x_commit_kill_o, x_result_ready_o, x_mem_ready_o;
    logic x_mem_data_req_o, x_stall_o, x_illegal_insn_o, x_protocol_err_o;
    logic [3:0] x_issue_req_id_o, x_commit_id_o;
    logic [2:0] x_issue_req_rs_valid_o, x_outstanding_o;

    always #5 clk = ~clk;

    cv32e40p_x_disp_mo dut (
        .clk_i(clk), .rst_i(rst), .x_illegal_insn_dec_i(illegal), .x_branch_or_jump_i(bj),
        .id_ready_i(id_ready), .x_waddr_id_i(waddr), .x_rs_addr_i(rs), .x_regs_used_i(regs_used),
        .x_waddr_ex_i(waddr_ex), .x_waddr_wb_i(waddr_wb), .x_we_ex_i(we_ex), .x_we_wb_i(we_wb),
        .x_data_req_dec_i(data_req_dec), .flush_i(flush), .x_issue_valid_o(x_issue_valid_o),
        .x_issue_ready_i(issue_ready), .x_issue_resp_accept_i(accept), .x_issue_resp_writeback_i(wb),
        .x_issue_resp_loadstore_i(ls), .x_issue_req_id_o(x_issue_req_id_o),
        .x_issue_req_rs_valid_o(x_issue_req_rs_valid_o), .x_commit_valid_o(x_commit_valid_o),
        .x_commit_id_o(x_commit_id_o), .x_commit_kill_o(x_commit_kill_o), .x_result_valid_i(res_valid),
        .x_result_ready_o(x_result_ready_o), .x_result_id_i(res_id), .x_result_rd_i(res_rd),
        .x_result_we_i(res_we), .x_mem_valid_i(mem_valid), .x_mem_ready_o(x_mem_ready_o),
        .x_mem_data_req_o(x_mem_data_req_o), .x_stall_o(x_stall_o), .x_illegal_insn_o(x_illegal_insn_o),
        .x_outstanding_o(x_outstanding_o), .x_protocol_err_o(x_protocol_err_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { int id; int rd; bit we; } ent_t;
    ent_t fl[$];
    int sb[32];
    int nid, memc, cid;
    bit offl, cpend, perr;

    task automatic m_reset();
        fl.delete();
        foreach (sb[r]) sb[r] = 0;
        nid = 0; memc = 0; cid = 0; offl = 0; cpend = 0; perr = 0;
    endtask

    always @(negedge clk) begin
        bit full, rdsat, ev, hs, dep, st, perr_n;
        bit [2:0] rsv;
        int a, idx;
        ent_t e;
        if (rst) begin
            m_reset();
            chk("rst_issue_valid", x_issue_valid_o, 0);
            chk("rst_commit_valid", x_commit_valid_o, 0);
            chk("rst_result_ready", x_result_ready_o, 0);
            chk("rst_mem_ready", x_mem_ready_o, 0);
            chk("rst_mem_data_req", x_mem_data_req_o, 0);
            chk("rst_protocol_err", x_protocol_err_o, 0);
            chk("rst_outstanding", x_outstanding_o, 0);
        end else begin
            full  = fl.size() >= NE || memc == 15;
            rdsat = sb[waddr] == 3;
            ev    = illegal && !bj && !offl && !full && !rdsat;
            hs    = ev && issue_ready;
            dep   = 0;
            for (int i = 0; i < 3; i++) begin
                a      = rs[i];
                rsv[i] = a == 0 || !(sb[a] != 0 || (we_ex && waddr_ex == a) || (we_wb && waddr_wb == a));
                if (regs_used[i] && sb[a] != 0) dep = 1;
            end
            st = (ev && !issue_ready) || dep || (data_req_dec && memc != 0) || (illegal && bj) ||
                 (illegal && (full || rdsat)) || (mem_valid && !hs);
            chk("issue_valid", x_issue_valid_o, ev);
            chk("issue_id", x_issue_req_id_o, nid);
            chk("rs_valid", x_issue_req_rs_valid_o, rsv);
            chk("commit_valid", x_commit_valid_o, cpend);
            if (cpend) chk("commit_id", x_commit_id_o, cid);
            chk("commit_kill", x_commit_kill_o, cpend && flush);
            chk("stall", x_stall_o, st);
            chk("illegal_insn", x_illegal_insn_o, hs && !accept);
            chk("outstanding", x_outstanding_o, fl.size());
            chk("result_ready", x_result_ready_o, 1);
            chk("mem_ready", x_mem_ready_o, mem_valid);
            chk("mem_data_req", x_mem_data_req_o, mem_valid);
            chk("protocol_err", x_protocol_err_o, perr);
            if (hs && accept && wb && waddr != 0) sb[waddr]++;
            if (cpend && flush) begin
                idx = -1;
                for (int k = 0; k < fl.size(); k++) if (idx < 0 && fl[k].id == cid) idx = k;
                if (idx >= 0) begin
                    if (fl[idx].we && fl[idx].rd != 0 && sb[fl[idx].rd] > 0) sb[fl[idx].rd]--;
                    fl.delete(idx);
                end
            end
            perr_n = 0;
            if (res_valid) begin
                idx = -1;
`ifdef CV32E40P_X_RESULT_ID_CHECK_EN
                for (int k = 0; k < fl.size(); k++) if (idx < 0 && fl[k].id == int'(res_id)) idx = k;
                perr_n = idx < 0;
`else
                if (fl.size() > 0) idx = 0;
`endif
                if (idx >= 0) begin
                    fl.delete(idx);
                    if (res_we && res_rd != 0 && sb[res_rd] > 0) sb[res_rd]--;
                end
            end
            if (hs && accept) begin
                e.id = nid; e.rd = waddr; e.we = wb;
                fl.push_back(e);
            end
            if (hs && accept && ls && !(mem_valid && memc > 0)) memc++;
            else if (mem_valid && memc > 0 && !(hs && accept && ls)) memc--;
            offl  = id_ready ? 0 : ((hs && accept) ? 1 : offl);
            cpend = hs;
            cid   = nid;
            if (hs) nid = (nid + 1) % 16;
            perr  = perr_n;
        end
    end

    task automatic idle();
        illegal = 0; bj = 0; id_ready = 0; we_ex = 0; we_wb = 0; data_req_dec = 0; flush = 0;
        issue_ready = 1; accept = 0; wb = 0; ls = 0; res_valid = 0; res_we = 0; mem_valid = 0;
        waddr = 0; waddr_ex = 0; waddr_wb = 0; res_rd = 0; rs = '0; regs_used = 0; res_id = 0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        illegal = 1;
        rst = 1;
        settle();
        chk("rst_gates_issue", x_issue_valid_o, 0);
        tick();
        rst = 0;
    endtask

    task automatic offload(input logic [4:0] rd, input bit clr);
        idle();
        illegal = 1; id_ready = clr; waddr = rd; accept = 1; wb = 1;
    endtask

    task automatic result(input logic [3:0] id, input logic [4:0] rd);
        res_valid = 1; res_id = id; res_rd = rd; res_we = 1;
    endtask

    initial begin
        // single offload, commit next cycle, result clears scoreboard
        do_reset();
        offload(5, 0);
        settle(); chk("t1_valid", x_issue_valid_o, 1); chk("t1_id", x_issue_req_id_o, 0); tick();
        idle(); id_ready = 1; rs[0] = 5;
        settle(); chk("t1_commit_valid", x_commit_valid_o, 1); chk("t1_commit_id", x_commit_id_o, 0);
        chk("t1_rs5_busy", x_issue_req_rs_valid_o[0], 0); tick();
        idle(); rs[0] = 5; result(0, 5); tick();
        idle(); rs[0] = 5;
        settle(); chk("t1_rs5_free", x_issue_req_rs_valid_o[0], 1); chk("t1_out", x_outstanding_o, 0); tick();

        // fill the table, fifth blocked until a result frees an entry
        do_reset();
        for (int k = 0; k < 4; k++) begin
            offload(5'(k + 1), 1);
            settle(); chk("t2_id", x_issue_req_id_o, k); tick();
        end
        offload(7, 1);
        settle(); chk("t2_full_valid", x_issue_valid_o, 0); chk("t2_full_stall", x_stall_o, 1);
        chk("t2_full_out", x_outstanding_o, 4); tick();
        offload(7, 1); result(0, 1);
        settle(); chk("t2_still_full", x_issue_valid_o, 0); tick();
        offload(7, 1);
        settle(); chk("t2_freed_valid", x_issue_valid_o, 1); chk("t2_freed_id", x_issue_req_id_o, 4); tick();

        // same-cycle issue and result on rd 7 leaves count at 1
        idle(); result(1, 2); tick();
        offload(7, 1); result(4, 7);
        settle(); chk("t3_valid", x_issue_valid_o, 1); chk("t3_id", x_issue_req_id_o, 5); tick();
        idle(); rs[1] = 7; result(5, 7);
        settle(); chk("t3_rs7_busy", x_issue_req_rs_valid_o[1], 0); tick();
        idle(); rs[1] = 7;
        settle(); chk("t3_rs7_free", x_issue_req_rs_valid_o[1], 1); tick();

        // rejected offload
        do_reset();
        offload(9, 0); accept = 0;
        settle(); chk("t4_illegal", x_illegal_insn_o, 1); chk("t4_id", x_issue_req_id_o, 0); tick();
        idle();
        settle(); chk("t4_illegal_gone", x_illegal_insn_o, 0); chk("t4_commit", x_commit_valid_o, 1);
        chk("t4_out", x_outstanding_o, 0); tick();
        offload(9, 1);
        settle(); chk("t4_next_id", x_issue_req_id_o, 1); tick();

        // killed commit, late result, mem counter
        do_reset();
        offload(10, 0); ls = 1;
        settle(); chk("t5_id", x_issue_req_id_o, 0); tick();
        idle(); id_ready = 1; flush = 1; data_req_dec = 1;
        settle(); chk("t5_kill", x_commit_kill_o, 1); chk("t5_mem_stall", x_stall_o, 1); tick();
        idle(); rs[2] = 10; result(0, 10);
        settle(); chk("t5_out", x_outstanding_o, 0); chk("t5_rs10_free", x_issue_req_rs_valid_o[2], 1); tick();
        idle(); mem_valid = 1;
`ifdef CV32E40P_X_RESULT_ID_CHECK_EN
        settle(); chk("t5_prot_err", x_protocol_err_o, 1);
`else
        settle(); chk("t5_prot_err", x_protocol_err_o, 0);
`endif
        chk("t5_mem_ready", x_mem_ready_o, 1); chk("t5_mem_stall2", x_stall_o, 1); tick();
        idle(); data_req_dec = 1;
        settle(); chk("t5_mem_drained", x_stall_o, 0); tick();

        // ID wrap, then rd saturation
        do_reset();
        for (int k = 0; k < 16; k++) begin
            offload(11, 1);
            settle(); chk("t6_id", x_issue_req_id_o, k); tick();
            idle(); result(4'(k), 11); tick();
        end
        offload(11, 1);
        settle(); chk("t6_wrap_id", x_issue_req_id_o, 0); tick();
        idle(); result(0, 11); tick();
        for (int k = 0; k < 3; k++) begin
            offload(3, 1);
            settle(); chk("t6_rd3_valid", x_issue_valid_o, 1); tick();
        end
        offload(3, 1);
        settle(); chk("t6_rdsat_valid", x_issue_valid_o, 0); chk("t6_rdsat_stall", x_stall_o, 1);
        chk("t6_rdsat_out", x_outstanding_o, 3); tick();

        idle();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
